// File: rtl/sdram_sched_pkg.sv
// Shared state encodings, defaults and watchdog limit for the SDRAM burst
// request scheduler and its address generators.
package sdram_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WREQ   = 3'd1,
    S_WBURST = 3'd2,
    S_RREQ   = 3'd3,
    S_RBURST = 3'd4,
    S_GAP    = 3'd5
  } sched_state_e;

  localparam int         DEF_ADDR_W    = 24;
  localparam int         DEF_BURST_LEN = 256;
  localparam logic [9:0] WDOG_LIMIT    = 10'd1023;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/sdram_addr_gen.sv
// One burst address pointer: tracks/loads its start bound, advances by
// BURST_LEN on burst completion and wraps to start at the exclusive end bound.
module sdram_addr_gen
  import sdram_sched_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              track_i,
  input  logic              load_i,
  input  logic              hold_i,
  input  logic              done_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] start_i,
  input  logic [ADDR_W-1:0] end_i,
  output logic [ADDR_W-1:0] ptr_o
);

  localparam logic [ADDR_W:0] STEP = (ADDR_W + 1)'(BURST_LEN);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W:0]   sum;
  logic              wrap;

  // One extra bit so ptr + BURST_LEN never overflows before the end compare.
  assign sum  = {1'b0, ptr_q} + STEP;
  assign wrap = (sum >= {1'b0, end_i});

  always_comb begin
    ptr_d  = ptr_q;
    pend_d = pend_q;
    if (track_i) begin
      ptr_d  = start_i;
      pend_d = 1'b0;
    end else if (done_i) begin
      ptr_d  = (pend_q | load_i | wrap) ? start_i : sum[ADDR_W-1:0];
      pend_d = 1'b0;
    end else if (abort_i) begin
      if (pend_q | load_i) ptr_d = start_i;
      pend_d = 1'b0;
    end else if (load_i) begin
      // A load during this pointer's own burst waits for the burst to end.
      if (hold_i) pend_d = 1'b1;
      else        ptr_d  = start_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      pend_q <= pend_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sdram_req_sched.sv
// Arbitrates write/read SDRAM burst requests from FIFO levels, counts acks and
// advances the region pointers. Optional burst watchdog: SDRAM_REQ_TIMEOUT_EN.
module sdram_req_sched
  import sdram_sched_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FIFO_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [FIFO_W-1:0] wr_fifo_used,
  input  logic [FIFO_W-1:0] rd_fifo_free,
  input  logic [ADDR_W-1:0] wr_start,
  input  logic [ADDR_W-1:0] wr_end,
  input  logic [ADDR_W-1:0] rd_start,
  input  logic [ADDR_W-1:0] rd_end,
  input  logic              addr_load,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [8:0]        sdwr_byte,
  output logic [8:0]        sdrd_byte,
  output logic [ADDR_W-1:0] sys_wraddr,
  output logic [ADDR_W-1:0] sys_rdaddr,
  output logic              busy,
  output logic              sched_err
);

  localparam logic [8:0]  BL9  = 9'(BURST_LEN);
  localparam logic [31:0] BL32 = 32'(BURST_LEN);

  sched_state_e state_q, state_d;
  logic [8:0]   cnt_q, cnt_d;
  logic         last_dir_q, last_dir_d;
  logic         wr_req_q, rd_req_q;
  logic         wr_elig, rd_elig;
  logic         wr_serving, rd_serving;
  logic         wr_done, rd_done;
  logic         wr_abort, rd_abort;
  logic         timeout_hit;

  assign wr_elig = wr_en & sdram_init_done & (32'(wr_fifo_used) >= BL32);
  assign rd_elig = rd_en & sdram_init_done & (32'(rd_fifo_free) >= BL32);

  assign wr_serving = (state_q == S_WREQ) || (state_q == S_WBURST);
  assign rd_serving = (state_q == S_RREQ) || (state_q == S_RBURST);

  // Completion is seen on the ack that brings the count to BURST_LEN.
  assign wr_done = wr_serving & sdram_wr_ack & ((cnt_q + 9'd1) == BL9);
  assign rd_done = rd_serving & sdram_rd_ack & ((cnt_q + 9'd1) == BL9);

  assign wr_abort = timeout_hit & wr_serving;
  assign rd_abort = timeout_hit & rd_serving;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dir_d = last_dir_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (wr_elig && (!rd_elig || last_dir_q == DIR_RD)) begin
          state_d    = S_WREQ;
          last_dir_d = DIR_WR;
        end else if (rd_elig) begin
          state_d    = S_RREQ;
          last_dir_d = DIR_RD;
        end
      end
      S_WREQ, S_WBURST: begin
        if (sdram_wr_ack) begin
          cnt_d   = cnt_q + 9'd1;
          state_d = wr_done ? S_GAP : S_WBURST;
        end
      end
      S_RREQ, S_RBURST: begin
        if (sdram_rd_ack) begin
          cnt_d   = cnt_q + 9'd1;
          state_d = rd_done ? S_GAP : S_RBURST;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_GAP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_dir_q <= DIR_RD;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dir_q <= last_dir_d;
      // Request falls on the edge that samples the first ack.
      wr_req_q   <= (state_d == S_WREQ);
      rd_req_q   <= (state_d == S_RREQ);
    end
  end

`ifdef SDRAM_REQ_TIMEOUT_EN
  logic [9:0] wdog_q, wdog_d;
  logic       err_q;

  assign wdog_d      = (wr_serving | rd_serving) ? (wdog_q + 10'd1) : 10'd0;
  assign timeout_hit = (wr_serving | rd_serving) & (wdog_q == WDOG_LIMIT) &
                       ~wr_done & ~rd_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= timeout_hit;
    end
  end

  assign sched_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign sched_err   = 1'b0;
`endif

  sdram_addr_gen #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN)
  ) u_wr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .track_i (~sdram_init_done),
    .load_i  (addr_load),
    .hold_i  (wr_serving),
    .done_i  (wr_done),
    .abort_i (wr_abort),
    .start_i (wr_start),
    .end_i   (wr_end),
    .ptr_o   (sys_wraddr)
  );

  sdram_addr_gen #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN)
  ) u_rd_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .track_i (~sdram_init_done),
    .load_i  (addr_load),
    .hold_i  (rd_serving),
    .done_i  (rd_done),
    .abort_i (rd_abort),
    .start_i (rd_start),
    .end_i   (rd_end),
    .ptr_o   (sys_rdaddr)
  );

  assign sdram_wr_req = wr_req_q;
  assign sdram_rd_req = rd_req_q;
  assign sdwr_byte    = BL9;
  assign sdrd_byte    = BL9;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/sdram_req_sched.md
SDRAM_REQ_SCHED -- requirements
Module: sdram_req_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 256: words per burst, legal range 1-256.
REQ-002 SHALL have parameter ADDR_W, default 24: word address width, {bank[1:0], row[12:0], col[8:0]}.
REQ-003 SHALL have parameter FIFO_W, default 10: width of the FIFO level inputs.
REQ-004 clk  in  1  system clock, 100MHz.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 sdram_init_done  in  1  controller initialisation complete.
REQ-007 wr_en / rd_en  in  1 each  enable write / read scheduling.
REQ-008 wr_fifo_used  in  FIFO_W  words held in the write FIFO.
REQ-009 rd_fifo_free  in  FIFO_W  free words in the read FIFO.
REQ-010 wr_start, wr_end, rd_start, rd_end  in  ADDR_W each  region bounds; each end is exclusive.
REQ-011 addr_load  in  1  pulse; reloads both pointers from their start inputs.
REQ-012 sdram_wr_ack / sdram_rd_ack  in  1 each  per-word ack from the controller.
REQ-013 sdram_wr_req / sdram_rd_req  out  1 each  burst request to the controller.
REQ-014 sdwr_byte / sdrd_byte  out  9 each  burst length to the controller.
REQ-015 sys_wraddr / sys_rdaddr  out  ADDR_W each  burst start address.
REQ-016 busy  out  1  a burst is in progress.
REQ-017 sched_err  out  1  one-cycle timeout pulse (only when the timeout feature is compiled in).

Function
REQ-020 sdwr_byte and sdrd_byte SHALL be constant BURST_LEN[8:0].
REQ-021 Write eligibility SHALL be: wr_en & sdram_init_done & (wr_fifo_used >= BURST_LEN).
REQ-022 Read eligibility SHALL be: rd_en & sdram_init_done & (rd_fifo_free >= BURST_LEN).
REQ-023 States SHALL be IDLE, WREQ, WBURST, RREQ, RBURST, GAP.
REQ-024 In IDLE with exactly one direction eligible, the FSM SHALL go to WREQ or RREQ on the next clock.
REQ-025 In IDLE with both directions eligible, the FSM SHALL serve the direction opposite to last_dir; last_dir resets to read, so the first contest goes to write.
REQ-026 The req output SHALL be registered, high throughout WREQ/RREQ, and SHALL drop in the same cycle the first ack is sampled.
- On that cycle the FSM moves to WBURST/RBURST.
- This prevents the controller re-triggering on return to its idle state.
REQ-027 A 9-bit ack counter SHALL clear on entry to WREQ/RREQ and SHALL increment on every matching ack cycle, including the first.
REQ-028 A burst SHALL complete when the counter reaches BURST_LEN.
- The pointer then becomes ptr + BURST_LEN, or start if ptr + BURST_LEN >= end (wrap).
- The FSM goes to GAP, then to IDLE one cycle later.
REQ-029 Pointer arithmetic SHALL be ADDR_W+1 bits wide so that the compare never overflows.
REQ-030 Acks of the direction not being served SHALL be ignored.
REQ-031 busy SHALL be high in every state except IDLE.
REQ-032 addr_load SHALL update both pointers on the next clock.
- If asserted mid-burst, the update is deferred until that burst completes, replacing the increment.
- While sdram_init_done=0, the pointers track their start inputs continuously.
REQ-033 Eligibility falling during a burst SHALL NOT abort the burst.

Reset
REQ-040 Asynchronous assertion SHALL force the following, regardless of any burst in flight:
- FSM to IDLE; req outputs, busy and sched_err to 0.
- Ack counter and both pointers to 0; last_dir to read.
REQ-041 Deassertion SHALL be sampled synchronously; after reset, scheduling resumes only under REQ-024/025.

Configuration
REQ-050 The macro SDRAM_REQ_TIMEOUT_EN SHALL control a burst timeout.
- Defined: a 10-bit watchdog clears on entry to WREQ/RREQ. If it reaches 1023 before completion, the FSM drops req, pulses sched_err for one cycle, leaves the pointer unchanged and goes to GAP.
- Undefined: no watchdog logic is generated and sched_err is tied to 0.

Structure
REQ-060 Shared package sdram_sched_pkg SHALL hold the state encodings, the default ADDR_W/BURST_LEN and the timeout limit 1023.
REQ-061 Sub-module sdram_addr_gen SHALL implement one pointer (load, advance-by-BURST_LEN, wrap); it is instantiated twice.

Verification
REQ-070 Write only: wr_fifo_used=256, wr_start=0, wr_end=1024 -> one sdram_wr_req, released on the first ack; 256 acks; sys_wraddr=256 after GAP.
REQ-071 Wrap: wr_start=0x100, wr_end=0x300, four bursts -> sys_wraddr sequence 0x100, 0x200, 0x100, 0x200.
REQ-072 Contest: both directions eligible continuously -> grants alternate W, R, W, R; no cycle has both reqs high.
REQ-073 Ineligible: rd_fifo_free=255 with BURST_LEN=256 -> sdram_rd_req never asserts; sdram_init_done=0 -> no requests at all.
REQ-074 Mid-burst events: rst_n low at ack 100 -> all outputs 0 immediately, no request until eligible again. addr_load at ack 50 -> pointer equals start after completion.
REQ-075 With SDRAM_REQ_TIMEOUT_EN, no ack -> sched_err pulses once at 1023 cycles and the pointer is unchanged. Without the macro, sched_err stays 0.
